// File: rtl/mips_mem_pkg.sv
// Shared types and default widths for the unified-memory arbiter.
package mips_mem_pkg;

    localparam int unsigned ADDR_W_DEF  = 32;
    localparam int unsigned DATA_W_DEF  = 32;
    localparam int unsigned MEM_LAT_DEF = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_DM = 1'b1
    } grant_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Two-way round-robin selector between fetch and data requesters.
module mem_arb_pick
    import mips_mem_pkg::*;
(
    input  logic   if_req_v,
    input  logic   dm_req_v,
    input  grant_t last_grant,
    output logic   gnt_valid_c,
    output grant_t gnt_c
);

    // On a tie, the requester not served last wins.
    always_comb begin
        gnt_valid_c = if_req_v | dm_req_v;
        gnt_c       = GNT_IF;
        if (if_req_v && dm_req_v) begin
            gnt_c = (last_grant == GNT_IF) ? GNT_DM : GNT_IF;
        end else if (dm_req_v) begin
            gnt_c = GNT_DM;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between fetch (IF) and data (DM) requesters,
// sequencing each access over MEM_LAT cycles and returning done pulses.
module mem_arbiter
    import mips_mem_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned MEM_LAT = MEM_LAT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_kill,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_stall,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_done,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_stall,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              arb_busy
);

    localparam int unsigned CNT_W = $clog2(MEM_LAT + 1);

    arb_state_t        state_q, state_d;
    grant_t            last_grant_q, last_grant_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              kill_q, kill_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_we_q, mem_we_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

    logic   gnt_valid_c;
    grant_t gnt_c;
    logic   in_done_c;

    mem_arb_pick u_pick (
        .if_req_v    (if_req & ~if_kill),
        .dm_req_v    (dm_req),
        .last_grant  (last_grant_q),
        .gnt_valid_c (gnt_valid_c),
        .gnt_c       (gnt_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= GNT_IF;
            cnt_q        <= '0;
            kill_q       <= 1'b0;
            mem_addr_q   <= '0;
            mem_we_q     <= 1'b0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            kill_q       <= kill_d;
            mem_addr_q   <= mem_addr_d;
            mem_we_q     <= mem_we_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    // Next-state: grant in IDLE, strobe in ISSUE, count down in WAIT.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        kill_d       = kill_q;
        mem_addr_d   = mem_addr_q;
        mem_we_d     = mem_we_q;
        mem_wdata_d  = mem_wdata_q;

        case (state_q)
            IDLE: begin
                kill_d = 1'b0;
                if (gnt_valid_c) begin
                    state_d      = ISSUE;
                    last_grant_d = gnt_c;
                    if (gnt_c == GNT_DM) begin
                        mem_addr_d  = dm_addr;
                        mem_we_d    = dm_we;
                        mem_wdata_d = dm_wdata;
                    end else begin
                        mem_addr_d  = if_addr;
                        mem_we_d    = 1'b0;
                        mem_wdata_d = '0;
                    end
                end
            end
            ISSUE: begin
                cnt_d   = CNT_W'(MEM_LAT - 1);
                state_d = (MEM_LAT == 1) ? DONE : WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A flushed fetch still completes in memory but its result is dropped.
        if (if_kill && (state_q != IDLE) && (last_grant_q == GNT_IF)) begin
            kill_d = 1'b1;
        end
    end

    assign in_done_c = (state_q == DONE);

    assign mem_en    = (state_q == ISSUE);
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign arb_busy  = (state_q != IDLE);

    assign if_done  = in_done_c & (last_grant_q == GNT_IF) & ~kill_q & ~if_kill;
    assign dm_done  = in_done_c & (last_grant_q == GNT_DM);
    assign if_rdata = if_done ? mem_rdata : '0;
    assign dm_rdata = (dm_done & ~mem_we_q) ? mem_rdata : '0;
    assign if_stall = if_req & ~if_done;
    assign dm_stall = dm_req & ~dm_done;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a 2-cycle-read memory model.
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_kill;
    logic        if_done;
    logic [31:0] if_rdata;
    logic        if_stall;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_done;
    logic [31:0] dm_rdata;
    logic        dm_stall;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        arb_busy;

    int passed;
    int total;

    logic [31:0] mem [256];
    logic [31:0] rd1;
    logic [31:0] rd2;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_kill   (if_kill),
        .if_done   (if_done),
        .if_rdata  (if_rdata),
        .if_stall  (if_stall),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_done   (dm_done),
        .dm_rdata  (dm_rdata),
        .dm_stall  (dm_stall),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .arb_busy  (arb_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word memory: data captured at the mem_en edge, presented one edge later.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
            rd1 <= mem[mem_addr[9:2]];
        end
        rd2 <= rd1;
    end
    assign mem_rdata = rd2;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        if_req  = 1'b0;
        if_kill = 1'b0;
        dm_req  = 1'b0;
        dm_we   = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        passed   = 0;
        total    = 0;
        rd1      = '0;
        rd2      = '0;
        if_addr  = '0;
        dm_addr  = '0;
        dm_wdata = '0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 | 32'(i * 4);

        // Reset values
        do_reset();
        neg();
        chk1("rst_mem_en", mem_en, 1'b0);
        chk1("rst_mem_we", mem_we, 1'b0);
        chk32("rst_mem_addr", mem_addr, 32'h0);
        chk1("rst_busy", arb_busy, 1'b0);
        chk1("rst_if_done", if_done, 1'b0);
        chk1("rst_dm_done", dm_done, 1'b0);

        // 1: lone fetch of 0x4
        tick(); if_req = 1'b1; if_addr = 32'h4;
        neg();
        chk1("t1_c0_stall", if_stall, 1'b1);
        chk1("t1_c0_mem_en", mem_en, 1'b0);
        tick(); neg();
        chk1("t1_c1_mem_en", mem_en, 1'b1);
        chk32("t1_c1_addr", mem_addr, 32'h4);
        chk1("t1_c1_we", mem_we, 1'b0);
        chk1("t1_c1_stall", if_stall, 1'b1);
        tick(); neg();
        chk1("t1_c2_mem_en", mem_en, 1'b0);
        chk1("t1_c2_done", if_done, 1'b0);
        chk1("t1_c2_stall", if_stall, 1'b1);
        tick(); neg();
        chk1("t1_c3_done", if_done, 1'b1);
        chk32("t1_c3_rdata", if_rdata, 32'h1000_0004);
        chk1("t1_c3_stall", if_stall, 1'b0);
        tick(); if_req = 1'b0;
        neg();
        chk1("t1_c4_busy", arb_busy, 1'b0);
        chk32("t1_c4_rdata0", if_rdata, 32'h0);

        // 2: tie after reset, DM first
        do_reset();
        if_req = 1'b1; if_addr = 32'h8;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h100;
        neg();
        chk1("t2_c0_if_stall", if_stall, 1'b1);
        chk1("t2_c0_dm_stall", dm_stall, 1'b1);
        tick(); neg();
        chk1("t2_c1_mem_en", mem_en, 1'b1);
        chk32("t2_c1_addr", mem_addr, 32'h100);
        tick(); neg();
        chk1("t2_c2_if_stall", if_stall, 1'b1);
        tick(); neg();
        chk1("t2_c3_dm_done", dm_done, 1'b1);
        chk32("t2_c3_dm_rdata", dm_rdata, 32'h1000_0100);
        chk1("t2_c3_if_done", if_done, 1'b0);
        chk1("t2_c3_if_stall", if_stall, 1'b1);
        chk1("t2_c3_dm_stall", dm_stall, 1'b0);
        tick(); dm_req = 1'b0;
        neg();
        chk1("t2_c4_busy", arb_busy, 1'b0);
        chk1("t2_c4_if_stall", if_stall, 1'b1);
        tick(); neg();
        chk1("t2_c5_mem_en", mem_en, 1'b1);
        chk32("t2_c5_addr", mem_addr, 32'h8);
        tick(); neg();
        chk1("t2_c6_if_stall", if_stall, 1'b1);
        tick(); neg();
        chk1("t2_c7_if_done", if_done, 1'b1);
        chk32("t2_c7_if_rdata", if_rdata, 32'h1000_0008);
        tick(); if_req = 1'b0;

        // 3: both held, strict D/I alternation
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h40;
        if_req = 1'b1; if_addr = 32'h44;
        for (int k = 0; k < 16; k++) begin
            neg();
            chk1("t3_mem_en", mem_en, (k % 4) == 1);
            if ((k % 4) == 1) chk32("t3_addr", mem_addr, ((k / 4) % 2 == 0) ? 32'h40 : 32'h44);
            if ((k % 4) == 3) chk1("t3_dm_done", dm_done, (k / 4) % 2 == 0);
            tick();
        end
        dm_req = 1'b0;
        if_req = 1'b0;

        // 4: DM write then IF read-back
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h10; dm_wdata = 32'hDEAD_BEEF;
        neg();
        chk1("t4_c0_dm_stall", dm_stall, 1'b1);
        tick(); neg();
        chk1("t4_c1_mem_en", mem_en, 1'b1);
        chk1("t4_c1_we", mem_we, 1'b1);
        chk32("t4_c1_addr", mem_addr, 32'h10);
        chk32("t4_c1_wdata", mem_wdata, 32'hDEAD_BEEF);
        tick(); neg();
        chk1("t4_c2_mem_en", mem_en, 1'b0);
        chk1("t4_c2_we_hold", mem_we, 1'b1);
        tick(); neg();
        chk1("t4_c3_dm_done", dm_done, 1'b1);
        chk32("t4_c3_dm_rdata", dm_rdata, 32'h0);
        tick(); dm_req = 1'b0; dm_we = 1'b0; if_req = 1'b1; if_addr = 32'h10;
        tick(); neg();
        chk1("t4_c5_mem_en", mem_en, 1'b1);
        chk1("t4_c5_we", mem_we, 1'b0);
        tick(); tick(); neg();
        chk1("t4_c7_if_done", if_done, 1'b1);
        chk32("t4_c7_if_rdata", if_rdata, 32'hDEAD_BEEF);
        tick(); if_req = 1'b0;

        // 5: fetch killed mid-flight, then a fresh fetch
        if_req = 1'b1; if_addr = 32'hC;
        tick(); neg();
        chk1("t5_c1_mem_en", mem_en, 1'b1);
        tick(); if_kill = 1'b1; if_req = 1'b0;
        neg();
        chk1("t5_c2_stall", if_stall, 1'b0);
        tick(); if_kill = 1'b0;
        neg();
        chk1("t5_c3_if_done", if_done, 1'b0);
        chk32("t5_c3_if_rdata", if_rdata, 32'h0);
        chk1("t5_c3_busy", arb_busy, 1'b1);
        tick(); if_req = 1'b1; if_addr = 32'h14;
        neg();
        chk1("t5_c4_busy", arb_busy, 1'b0);
        tick(); neg();
        chk1("t5_c5_mem_en", mem_en, 1'b1);
        chk32("t5_c5_addr", mem_addr, 32'h14);
        tick(); tick(); neg();
        chk1("t5_c7_if_done", if_done, 1'b1);
        chk32("t5_c7_if_rdata", if_rdata, 32'h1000_0014);
        tick(); if_req = 1'b0;

        // 6: reset during a DM read
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h20;
        tick(); neg();
        chk1("t6_c1_mem_en", mem_en, 1'b1);
        chk32("t6_c1_addr", mem_addr, 32'h20);
        tick(); rst = 1'b1; dm_req = 1'b0;
        tick(); rst = 1'b0;
        neg();
        chk1("t6_c3_mem_en", mem_en, 1'b0);
        chk1("t6_c3_we", mem_we, 1'b0);
        chk32("t6_c3_addr", mem_addr, 32'h0);
        chk32("t6_c3_wdata", mem_wdata, 32'h0);
        chk1("t6_c3_dm_done", dm_done, 1'b0);
        chk32("t6_c3_dm_rdata", dm_rdata, 32'h0);
        chk1("t6_c3_busy", arb_busy, 1'b0);
        chk1("t6_c3_if_done", if_done, 1'b0);
        chk1("t6_c3_dm_stall", dm_stall, 1'b0);
        tick(); dm_req = 1'b1; dm_addr = 32'h24; if_req = 1'b1; if_addr = 32'h28;
        neg();
        chk1("t6_c4_dm_done", dm_done, 1'b0);
        tick(); neg();
        chk1("t6_c5_mem_en", mem_en, 1'b1);
        chk32("t6_c5_addr", mem_addr, 32'h24);
        tick(); tick(); neg();
        chk1("t6_c7_dm_done", dm_done, 1'b1);
        chk32("t6_c7_dm_rdata", dm_rdata, 32'h1000_0024);
        chk1("t6_c7_if_stall", if_stall, 1'b1);
        tick(); dm_req = 1'b0;
        tick(); neg();
        chk1("t6_c9_mem_en", mem_en, 1'b1);
        chk32("t6_c9_addr", mem_addr, 32'h28);
        tick(); tick(); neg();
        chk1("t6_c11_if_done", if_done, 1'b1);
        chk32("t6_c11_if_rdata", if_rdata, 32'h1000_0028);
        tick(); if_req = 1'b0;
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
